// File: rtl/fb_write_gen_pkg.sv
// Shared types and defaults for the frame-buffer write path.
package fb_write_gen_pkg;

    localparam int unsigned H_RES_DEF = 320;
    localparam int unsigned V_RES_DEF = 240;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned PIX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DRAIN
    } fbw_state_t;

    // Counter width that stays legal when a dimension is 1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_xy_counter.sv
// Raster position counter: x/y with wrap, linear address kept in step without a multiplier.
module fb_xy_counter
    import fb_write_gen_pkg::*;
#(
    parameter int unsigned H_RES  = H_RES_DEF,
    parameter int unsigned V_RES  = V_RES_DEF,
    parameter int unsigned ADDR_W = FB_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              restart,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    localparam int unsigned X_W = cnt_w(H_RES);
    localparam int unsigned Y_W = cnt_w(V_RES);
    // Position immediately after the origin, used when a SOF pixel lands on address 0.
    localparam int unsigned R_X = (H_RES > 1) ? 1 : 0;
    localparam int unsigned R_Y = (H_RES == 1 && V_RES > 1) ? 1 : 0;
    localparam int unsigned R_A = (H_RES * V_RES > 1) ? 1 : 0;

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           x_end;
    logic           y_end;

    assign x_end  = (x == X_W'(H_RES - 1));
    assign y_end  = (y == Y_W'(V_RES - 1));
    assign last_c = x_end && y_end;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (restart) begin
            x    <= X_W'(R_X);
            y    <= Y_W'(R_Y);
            addr <= ADDR_W'(R_A);
        end else if (step) begin
            if (x_end) begin
                x <= '0;
                if (y_end) begin
                    y    <= '0;
                    addr <= '0;
                end else begin
                    y    <= y + Y_W'(1);
                    addr <= addr + ADDR_W'(1);
                end
            end else begin
                x    <= x + X_W'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_write_gen.sv
// Frame-buffer write generator: takes one raster frame from a pixel stream and emits RAM writes.
module fb_write_gen
    import fb_write_gen_pkg::*;
#(
    parameter int unsigned H_RES  = H_RES_DEF,
    parameter int unsigned V_RES  = V_RES_DEF,
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned PIX_W  = PIX_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    input  logic              mem_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err
);

    localparam bit SINGLE = (H_RES * V_RES == 1);

    fbw_state_t        state;
    fbw_state_t        state_nxt;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last_c;
    logic              cnt_clear_c;
    logic              cnt_restart_c;
    logic              cnt_step_c;
    logic              accept_c;
    logic              hold_c;
    logic              retire_c;
    logic              wr_load_c;
    logic              sof_set_c;
    logic              done_c;

    fb_xy_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_xy (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear_c),
        .restart (cnt_restart_c),
        .step    (cnt_step_c),
        .addr    (cnt_addr),
        .last_c  (cnt_last_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state, handshake and write-control decode.
    always_comb begin
        state_nxt     = state;
        pix_ready     = 1'b0;
        cnt_clear_c   = 1'b0;
        hold_c        = wr_en && mem_busy;
        retire_c      = wr_en && !mem_busy;
        done_c        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = ARM;
                    cnt_clear_c = 1'b1;
                end
            end
            ARM: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_sof) state_nxt = SINGLE ? DRAIN : CAPTURE;
            end
            CAPTURE: begin
                pix_ready = !hold_c;
                if (pix_valid && pix_ready) begin
                    if (pix_sof)         state_nxt = SINGLE ? DRAIN : CAPTURE;
                    else if (cnt_last_c) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (retire_c) begin
                    state_nxt = IDLE;
                    done_c    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        accept_c      = pix_valid && pix_ready;
        wr_load_c     = accept_c && ((state == CAPTURE) || (state == ARM && pix_sof));
        cnt_restart_c = wr_load_c && pix_sof;
        cnt_step_c    = wr_load_c && !pix_sof;
        sof_set_c     = accept_c && (state == CAPTURE) && pix_sof && (cnt_addr != ADDR_W'(0));
    end

    // Output holding register: a stalled write stays put until the RAM takes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            if (!hold_c) begin
                if (wr_load_c) begin
                    wr_en   <= 1'b1;
                    wr_addr <= pix_sof ? ADDR_W'(0) : cnt_addr;
                    wr_data <= pix_data;
                end else begin
                    wr_en   <= 1'b0;
                end
            end
            busy       <= (state_nxt != IDLE);
            frame_done <= done_c;
            if (cnt_clear_c)    sof_err <= 1'b0;
            else if (sof_set_c) sof_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_write_gen.sv
// Scoreboard bench for fb_write_gen: 4x3 directed frames plus one full default-size frame.
module tb_fb_write_gen;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // 4x3 instance
    logic        reset_n, start, pix_valid, pix_sof, pix_ready, mem_busy;
    logic [7:0]  pix_data, wr_data;
    logic        wr_en, busy, frame_done, sof_err;
    logic [16:0] wr_addr;

    // default 320x240 instance
    logic        b_reset_n, b_start, b_valid, b_sof, b_ready, b_mem_busy;
    logic [7:0]  b_data, b_wr_data;
    logic        b_wr_en, b_busy, b_frame_done, b_sof_err;
    logic [16:0] b_wr_addr;

    fb_write_gen #(.H_RES(4), .V_RES(3), .ADDR_W(17), .PIX_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready), .mem_busy(mem_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    fb_write_gen dut_big (
        .clock(clock), .reset_n(b_reset_n), .start(b_start), .pix_valid(b_valid),
        .pix_sof(b_sof), .pix_data(b_data), .pix_ready(b_ready), .mem_busy(b_mem_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .busy(b_busy),
        .frame_done(b_frame_done), .sof_err(b_sof_err)
    );

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    bit  prev_last = 1'b0;
    int  b_cnt = 0;
    int  b_bad = 0;
    bit  b_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one pixel until accepted; expected write (if any) goes to the scoreboard.
    task automatic send(input logic [7:0] d, input bit sof, input bit wr, input int a);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        do begin
            @(negedge clock);
            n++;
        end while (!pix_ready && n < 50);
        if (!pix_ready) check("send_timeout", 32'(pix_ready), 32'd1);
        else if (wr) sb.push_back('{addr: 17'(a), data: d});
        @(posedge clock);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor for the 4x3 instance.
    always @(negedge clock) begin
        if (frame_done || prev_last) check("frame_done", 32'(frame_done), 32'(prev_last));
        if (frame_done) done_cnt++;
        prev_last = 1'b0;
        if (wr_en && !mem_busy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual addr=%0d data=%0h required none", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
            prev_last = (wr_addr == 17'd11);
        end
    end

    // Monitor for the default-size instance.
    always @(negedge clock) begin
        if (b_wr_en && !b_mem_busy) begin
            if (b_wr_addr !== 17'(b_cnt) || b_wr_data !== 8'(b_cnt)) b_bad++;
            if (b_cnt == 320)   check("line_wrap_addr", 32'(b_wr_addr), 32'd320);
            if (b_cnt == 76799) check("last_addr", 32'(b_wr_addr), 32'd76799);
            b_cnt++;
        end
        if (b_frame_done) begin
            check("big_done_count", 32'(b_cnt), 32'd76800);
            b_done = 1'b1;
        end
    end

    // Full default frame, one pixel per cycle, no backpressure.
    initial begin
        b_reset_n = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_sof = 1'b0;
        b_data = '0; b_mem_busy = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        b_reset_n = 1'b1;
        @(posedge clock);
        #1;
        b_start = 1'b1;
        @(posedge clock);
        #1;
        b_start = 1'b0;
        for (int i = 0; i < 76800; i++) begin
            int n = 0;
            b_valid = 1'b1;
            b_sof   = (i == 0);
            b_data  = 8'(i);
            do begin
                @(negedge clock);
                n++;
            end while (!b_ready && n < 50);
            @(posedge clock);
            #1;
        end
        b_valid = 1'b0;
        b_sof   = 1'b0;
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        pix_data = '0; mem_busy = 1'b0;
        #2;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_sof_err", 32'(sof_err), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Full frame, no stalls
        pulse_start();
        for (int i = 0; i < 12; i++) send(8'h20 + 8'(i), i == 0, 1'b1, i);
        wait_idle();

        // RAM stall while address 5 is on the port
        pulse_start();
        for (int i = 0; i < 6; i++) send(8'h40 + 8'(i), i == 0, 1'b1, i);
        mem_busy  = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'h46;
        pix_sof   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("hold_wr_en", 32'(wr_en), 32'd1);
            check("hold_wr_addr", 32'(wr_addr), 32'd5);
            check("hold_wr_data", 32'(wr_data), 32'h45);
            check("hold_pix_ready", 32'(pix_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        mem_busy = 1'b0;
        for (int i = 6; i < 12; i++) send(8'h40 + 8'(i), 1'b0, 1'b1, i);
        wait_idle();

        // Non-SOF pixels in ARM are dropped
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0, 1'b0, 0);
        send(8'h60, 1'b1, 1'b1, 0);
        for (int i = 1; i < 12; i++) send(8'h60 + 8'(i), 1'b0, 1'b1, i);
        wait_idle();

        // Mid-frame SOF resynchronises to address 0
        pulse_start();
        for (int i = 0; i < 7; i++) send(8'h80 + 8'(i), i == 0, 1'b1, i);
        send(8'h87, 1'b1, 1'b1, 0);
        check("sof_err_set", 32'(sof_err), 32'd1);
        for (int i = 1; i < 12; i++) send(8'h90 + 8'(i), 1'b0, 1'b1, i);
        wait_idle();
        check("sof_err_sticky", 32'(sof_err), 32'd1);

        // Next start clears sof_err; then reset in the middle of the frame
        pulse_start();
        check("sof_err_cleared", 32'(sof_err), 32'd0);
        send(8'hC0, 1'b1, 1'b1, 0);
        send(8'hC1, 1'b0, 1'b1, 1);
        send(8'hC2, 1'b1, 1'b1, 0);
        check("pre_reset_sof_err", 32'(sof_err), 32'd1);
        pix_valid = 1'b1;
        pix_data  = 8'hC3;
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sof_err", 32'(sof_err), 32'd0);
        check("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_pix_ready", 32'(pix_ready), 32'd0);
        check("post_rst_frame_done", 32'(frame_done), 32'd0);
        pix_valid = 1'b0;

        // Clean frame after reset; a start pulse mid-frame must be ignored
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            start = (i == 4);
            send(8'hE0 + 8'(i), i == 0, 1'b1, i);
        end
        start = 1'b0;
        wait_idle();

        check("frames_done", 32'(done_cnt), 32'd5);
        check("sb_empty", 32'(sb.size()), 32'd0);

        begin
            int n = 0;
            while (!b_done && n < 90000) begin
                @(posedge clock);
                n++;
            end
        end
        check("big_frame_done", 32'(b_done), 32'd1);
        check("big_seq_errors", 32'(b_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
